// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: channel indices,
// per-channel FSM encoding, default timing constants and a counter-width helper.
package button_conditioner_pkg;

  localparam int BTN_UP     = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_MIDDLE = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

  localparam int N_BTN_DEF           = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;    // 20 ms at 100 MHz
  localparam int LONG_CYCLES_DEF     = 300_000_000;  // 3 s at 100 MHz
  localparam int REPEAT_CYCLES_DEF   = 20_000_000;   // 200 ms at 100 MHz

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_state_e;

  // Keeps counters at least one bit wide even for degenerate cycle counts.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/hold FSM and registered outputs.
// Auto-repeat in LONG_HELD is built only when BUTTON_CONDITIONER_AUTO_REPEAT_EN is defined.
module button_conditioner_btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level_o,
  output logic pulse_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic          s1_q, s2_q;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      rcnt_q      <= '0;
`endif
    end else begin
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      rcnt_q      <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    pulse_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    rcnt_d      = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s2_q) begin
          state_d = DEB_PRESS;
          dcnt_d  = '0;
        end
      end
      DEB_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = DEB_RELEASE;
          dcnt_d  = '0;
        end else if (hcnt_q == H_LAST) begin
          state_d     = LONG_HELD;
          long_d      = 1'b1;
          long_done_d = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
          rcnt_d      = '0;
`endif
        end else begin
          hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!s2_q) begin
          state_d = DEB_RELEASE;
          dcnt_d  = '0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
          rcnt_d  = '0;
        end else if (rcnt_q == R_LAST) begin
          pulse_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
`endif
        end
      end
      DEB_RELEASE: begin
        // A bounce back to 1 resumes the hold without a fresh press pulse.
        if (s2_q) begin
          state_d = long_done_q ? LONG_HELD : PRESSED;
        end else if (dcnt_q == D_LAST) begin
          state_d     = IDLE;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced level, press/release and long-press pulses.
// Optional auto-repeat: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    button_conditioner_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_btn_channel (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[gi]),
      .level_o  (btn_level[gi]),
      .pulse_o  (btn_pulse[gi]),
      .release_o(btn_release[gi]),
      .long_o   (btn_long[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, LONG=20, REPEAT=5.
module tb_button_conditioner;

  localparam int N = 5;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int EXP_REPEATS = 8;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_pulse, btn_release, btn_long;

  int total = 0;
  int bad   = 0;
  int cnt_pulse = 0;
  int cnt_rel   = 0;
  int cnt_long  = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES  (5)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] raw;
    int           cyc;
    logic [N-1:0] lvl;
    int           np;
    int           nr;
    int           nl;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cnt_pulse += $countones(btn_pulse);
    cnt_rel   += $countones(btn_release);
    cnt_long  += $countones(btn_long);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    cnt_pulse = 0;
    cnt_rel   = 0;
    cnt_long  = 0;
  endtask

  initial begin
    // glitch on bit 0
    vecs[0]  = '{5'b00001, 3,  5'b00000, 0, 0, 0};
    vecs[1]  = '{5'b00000, 10, 5'b00000, 0, 0, 0};
    // clean press, long press and release on bit 2
    vecs[2]  = '{5'b00100, 6,  5'b00000, 0, 0, 0};
    vecs[3]  = '{5'b00100, 1,  5'b00100, 1, 0, 0};
    vecs[4]  = '{5'b00100, 19, 5'b00100, 0, 0, 0};
    vecs[5]  = '{5'b00100, 1,  5'b00100, 0, 0, 1};
    vecs[6]  = '{5'b00000, 6,  5'b00100, 0, 0, 0};
    vecs[7]  = '{5'b00000, 1,  5'b00000, 0, 1, 0};
    vecs[8]  = '{5'b00000, 5,  5'b00000, 0, 0, 0};
    // press on bit 1 followed by release bounce
    vecs[9]  = '{5'b00010, 6,  5'b00000, 0, 0, 0};
    vecs[10] = '{5'b00010, 1,  5'b00010, 1, 0, 0};
    vecs[11] = '{5'b00010, 3,  5'b00010, 0, 0, 0};
    vecs[12] = '{5'b00000, 2,  5'b00010, 0, 0, 0};
    vecs[13] = '{5'b00010, 2,  5'b00010, 0, 0, 0};
    vecs[14] = '{5'b00000, 2,  5'b00010, 0, 0, 0};
    vecs[15] = '{5'b00010, 2,  5'b00010, 0, 0, 0};
    vecs[16] = '{5'b00000, 6,  5'b00010, 0, 0, 0};
    vecs[17] = '{5'b00000, 1,  5'b00000, 0, 1, 0};
    vecs[18] = '{5'b00000, 5,  5'b00000, 0, 0, 0};

    // reset state
    rst = 1'b0;
    run(3);
    check("reset_outputs", int'({btn_level, btn_pulse, btn_release, btn_long}), 0);
    @(negedge clk);
    rst = 1'b1;
    run(2);

    for (int v = 0; v < NV; v++) begin
      clr();
      btn_raw = vecs[v].raw;
      run(vecs[v].cyc);
      check($sformatf("vec%0d_level", v), int'(btn_level), int'(vecs[v].lvl));
      check($sformatf("vec%0d_pulses", v), cnt_pulse, vecs[v].np);
      check($sformatf("vec%0d_releases", v), cnt_rel, vecs[v].nr);
      check($sformatf("vec%0d_longs", v), cnt_long, vecs[v].nl);
    end

    // simultaneous press on bits 3 and 4
    clr();
    btn_raw = 5'b11000;
    run(6);
    check("simul_early_pulses", cnt_pulse, 0);
    step();
    check("simul_pulse", int'(btn_pulse), int'(5'b11000));
    check("simul_level", int'(btn_level), int'(5'b11000));
    btn_raw = 5'b00000;
    run(6);
    step();
    check("simul_release", int'(btn_release), int'(5'b11000));
    run(5);

    // asynchronous reset during PRESSED
    clr();
    btn_raw = 5'b00100;
    run(10);
    check("rst_pre_level", int'(btn_level), int'(5'b00100));
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_outputs", int'({btn_level, btn_pulse, btn_release, btn_long}), 0);
    clr();
    run(3);
    check("rst_no_release", cnt_rel, 0);
    @(negedge clk);
    rst = 1'b1;
    clr();
    run(6);
    check("rst_early_pulses", cnt_pulse, 0);
    step();
    check("rst_fresh_pulse", int'(btn_pulse), int'(5'b00100));
    btn_raw = 5'b00000;
    clr();
    run(12);
    check("rst_final_release", cnt_rel, 1);

    // auto-repeat on bit 0
    clr();
    btn_raw = 5'b00001;
    run(7);
    check("rep_press_pulse", int'(btn_pulse), 1);
    run(19);
    step();
    check("rep_long", int'(btn_long), 1);
    clr();
    run(40);
    check("rep_count", cnt_pulse, EXP_REPEATS);
    btn_raw = 5'b00000;
    clr();
    run(15);
    check("rep_after_release", cnt_pulse, 0);
    check("rep_release", cnt_rel, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
